staff_write_scheduler: RTL and testbench

- Sequences writes of quantized notes into the shared staff note memory: 64 staff cells x 8 voice slots, 5 voices used, one port.
- Latches the staff cell at note-on and, at note-off, writes {rhythm, note} to that cell.
- Round-robin arbitrates among the 5 voices, yields the memory port to the display reader, and clears the page whenever the staff cell counter wraps.
- Sits between the MIDI/duration front end plus note position/rhythm logic, and the staff memory BRAM.

---
 rtl/staff_write_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_staff_write_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/staff_write_scheduler.sv
// Staff write scheduler: shares one staff-memory port between display reads, page clears and voice note writes.
// Latency: a port decision made in cycle N appears on the registered mem_* outputs in cycle N+1.
// Backpressure: a display read always wins the port; the clear sweep and voice writes hold and retry.
module staff_write_scheduler #(
  parameter int          NUM_VOICES = 5,
  parameter int          NUM_CELLS  = 64,
  parameter logic [11:0] NULL_ENTRY = 12'h0FF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      cell_tick_in,
  input  logic [5:0]                current_cell_in,
  input  logic [NUM_VOICES-1:0]     note_start_in,
  input  logic [NUM_VOICES-1:0]     note_end_in,
  input  logic [8*NUM_VOICES-1:0]   note_in,
  input  logic [4*NUM_VOICES-1:0]   rhythm_in,
  input  logic                      rd_req_in,
  input  logic [8:0]                rd_addr_in,
  output logic                      rd_grant_out,
  output logic                      mem_en_out,
  output logic                      mem_we_out,
  output logic [8:0]                mem_addr_out,
  output logic [11:0]               mem_wdata_out,
  output logic                      clearing_out,
  output logic [7:0]                drop_count_out
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [5:0] LAST_CELL  = 6'(NUM_CELLS - 1);
  localparam logic [2:0] LAST_VOICE = 3'(NUM_VOICES - 1);

  state_t                state_q, state_d;
  logic                  page_q, page_d, wrap;
  logic [NUM_VOICES-1:0] open_q, pend_q, start_page_q;
  logic [NUM_VOICES-1:0] pend_clr, load, drop_start, drop_end;
  logic [5:0]            start_cell_q  [NUM_VOICES];
  logic [5:0]            slot_cell_q   [NUM_VOICES];
  logic [7:0]            slot_note_q   [NUM_VOICES];
  logic [3:0]            slot_rhythm_q [NUM_VOICES];
  logic [5:0]            load_cell     [NUM_VOICES];
  logic [2:0]            ptr_q, ptr_d;
  logic [5:0]            clr_cell_q, clr_cell_d;
  logic [2:0]            clr_voice_q, clr_voice_d;
  logic                  found;
  logic [2:0]            gnt_idx;
  logic                  grant_d, en_d, we_d;
  logic [8:0]            addr_d;
  logic [11:0]           wdata_d;
  logic                  grant_q, en_q, we_q, clearing_q;
  logic [8:0]            addr_q;
  logic [11:0]           wdata_q;
  logic [7:0]            drop_q, drop_d;
  logic [4:0]            drop_inc;
  logic [8:0]            drop_sum;

  // A wrap of the cell counter flips the page and restarts the clear sweep.
  always_comb begin
    wrap   = cell_tick_in && (current_cell_in == 6'd0);
    page_d = page_q ^ wrap;
  end

  // Round-robin search: first pending voice at or after the pointer.
  always_comb begin
    int idx;
    logic [2:0] idx3;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx3    = '0;
    for (int k = 0; k < NUM_VOICES; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_VOICES) idx = idx - NUM_VOICES;
      idx3 = 3'(idx);
      if (!found && pend_q[idx3]) begin
        found   = 1'b1;
        gnt_idx = idx3;
      end
    end
  end

  // Port decision and FSM next state: read first, then clear sweep, then voice writes.
  always_comb begin
    state_d     = state_q;
    clr_cell_d  = clr_cell_q;
    clr_voice_d = clr_voice_q;
    ptr_d       = ptr_q;
    pend_clr    = '0;
    grant_d     = 1'b0;
    en_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    if (rd_req_in) begin
      grant_d = 1'b1;
      en_d    = 1'b1;
      addr_d  = rd_addr_in;
    end else if (state_q == ST_CLEAR) begin
      en_d    = 1'b1;
      we_d    = 1'b1;
      addr_d  = {clr_cell_q, clr_voice_q};
      wdata_d = NULL_ENTRY;
      if (clr_voice_q == LAST_VOICE) begin
        clr_voice_d = '0;
        if (clr_cell_q == LAST_CELL) begin
          clr_cell_d = '0;
          state_d    = ST_RUN;
        end else begin
          clr_cell_d = clr_cell_q + 6'd1;
        end
      end else begin
        clr_voice_d = clr_voice_q + 3'd1;
      end
    end else if (found) begin
      en_d              = 1'b1;
      we_d              = 1'b1;
      addr_d            = {slot_cell_q[gnt_idx], gnt_idx};
      wdata_d           = {slot_rhythm_q[gnt_idx], slot_note_q[gnt_idx]};
      pend_clr[gnt_idx] = 1'b1;
      ptr_d             = (gnt_idx == LAST_VOICE) ? 3'd0 : gnt_idx + 3'd1;
    end
    // The decision above still issues; only the sweep state is restarted.
    if (wrap) begin
      state_d     = ST_CLEAR;
      clr_cell_d  = '0;
      clr_voice_d = '0;
    end
  end

  // Note-end loads and lost-note accounting; an end is resolved before a same-cycle start.
  always_comb begin
    load       = '0;
    drop_end   = '0;
    drop_start = '0;
    drop_inc   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      load[i]       = note_end_in[i] & open_q[i] & (rhythm_in[4*i +: 4] != 4'd0);
      drop_end[i]   = load[i] & pend_q[i] & ~pend_clr[i];
      drop_start[i] = note_start_in[i] & open_q[i] & ~note_end_in[i];
      load_cell[i]  = (start_page_q[i] == page_d) ? start_cell_q[i] : 6'd0;
      drop_inc      = drop_inc + 5'(drop_end[i]) + 5'(drop_start[i]);
    end
    drop_sum = {1'b0, drop_q} + 9'(drop_inc);
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Control state: FSM, page bit, pointer, sweep counter, drop counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_CLEAR;
      page_q      <= 1'b0;
      ptr_q       <= '0;
      clr_cell_q  <= '0;
      clr_voice_q <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      page_q      <= page_d;
      ptr_q       <= ptr_d;
      clr_cell_q  <= clr_cell_d;
      clr_voice_q <= clr_voice_d;
      drop_q      <= drop_d;
    end
  end

  // Per-voice start latches, open flags and pending write slots.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      open_q       <= '0;
      pend_q       <= '0;
      start_page_q <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        start_cell_q[i]  <= '0;
        slot_cell_q[i]   <= '0;
        slot_note_q[i]   <= '0;
        slot_rhythm_q[i] <= '0;
      end
    end else begin
      open_q <= note_start_in | (open_q & ~note_end_in);
      pend_q <= load | (pend_q & ~pend_clr);
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (note_start_in[i]) begin
          start_cell_q[i] <= current_cell_in;
          start_page_q[i] <= page_d;
        end
        if (load[i]) begin
          slot_cell_q[i]   <= load_cell[i];
          slot_note_q[i]   <= note_in[8*i +: 8];
          slot_rhythm_q[i] <= rhythm_in[4*i +: 4];
        end
      end
    end
  end

  // Registered memory port; clearing_out is aligned with the sweep writes it flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_q    <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      clearing_q <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      clearing_q <= (state_q == ST_CLEAR);
    end
  end

  assign rd_grant_out   = grant_q;
  assign mem_en_out     = en_q;
  assign mem_we_out     = we_q;
  assign mem_addr_out   = addr_q;
  assign mem_wdata_out  = wdata_q;
  assign clearing_out   = clearing_q;
  assign drop_count_out = drop_q;

endmodule

// File: tb/tb_staff_write_scheduler.sv
// Bench for staff_write_scheduler: directed scenarios plus random traffic against a behavioural model.
// Every cycle the memory port, clearing flag and drop counter are compared with the model.
// Directed scenarios add explicit checks on write counts, addresses and data.
module tb_staff_write_scheduler;
  localparam int NV = 5;

  logic            clk_in;
  logic            rst_in;
  logic            cell_tick_in;
  logic [5:0]      current_cell_in;
  logic [NV-1:0]   note_start_in;
  logic [NV-1:0]   note_end_in;
  logic [8*NV-1:0] note_in;
  logic [4*NV-1:0] rhythm_in;
  logic            rd_req_in;
  logic [8:0]      rd_addr_in;
  logic            rd_grant_out;
  logic            mem_en_out;
  logic            mem_we_out;
  logic [8:0]      mem_addr_out;
  logic [11:0]     mem_wdata_out;
  logic            clearing_out;
  logic [7:0]      drop_count_out;

  staff_write_scheduler #(.NUM_VOICES(NV), .NUM_CELLS(64), .NULL_ENTRY(12'h0FF)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cell_tick_in(cell_tick_in), .current_cell_in(current_cell_in),
    .note_start_in(note_start_in), .note_end_in(note_end_in), .note_in(note_in), .rhythm_in(rhythm_in),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_grant_out(rd_grant_out),
    .mem_en_out(mem_en_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .clearing_out(clearing_out), .drop_count_out(drop_count_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Behavioural model: clear progress as a linear index over 64 x NV entries.
  bit          m_clear;
  int          m_cidx;
  bit          m_page;
  bit          m_open  [NV];
  int          m_scell [NV];
  bit          m_spage [NV];
  bit          m_pend  [NV];
  int          m_pcell [NV];
  int          m_pnote [NV];
  int          m_prhy  [NV];
  int          m_ptr;
  int          m_drop;
  logic [23:0] e_port;
  bit          e_clr;

  task automatic model_step();
    int  grant;
    int  drops;
    int  v;
    int  r;
    bit  wrap;
    bit  np;
    if (rst_in) begin
      m_clear = 1; m_cidx = 0; m_page = 0; m_ptr = 0; m_drop = 0;
      for (int i = 0; i < NV; i++) begin
        m_open[i] = 0; m_scell[i] = 0; m_spage[i] = 0; m_pend[i] = 0;
        m_pcell[i] = 0; m_pnote[i] = 0; m_prhy[i] = 0;
      end
      e_port = '0;
      e_clr  = 0;
      return;
    end
    wrap  = cell_tick_in && (current_cell_in == 6'd0);
    np    = m_page ^ wrap;
    e_clr = m_clear;
    grant = -1;
    if (rd_req_in) begin
      e_port = {3'b110, rd_addr_in, 12'h000};
    end else if (m_clear) begin
      e_port = {3'b011, 9'((m_cidx / NV) * 8 + (m_cidx % NV)), 12'h0FF};
      m_cidx++;
      if (m_cidx == 64 * NV) begin
        m_clear = 0;
        m_cidx  = 0;
      end
    end else begin
      e_port = '0;
      for (int k = 0; k < NV; k++) begin
        v = (m_ptr + k) % NV;
        if (grant < 0 && m_pend[v]) grant = v;
      end
      if (grant >= 0) begin
        e_port = {3'b011, 9'(m_pcell[grant] * 8 + grant), 4'(m_prhy[grant]), 8'(m_pnote[grant])};
        m_pend[grant] = 0;
        m_ptr = (grant + 1) % NV;
      end
    end
    if (wrap) begin
      m_clear = 1;
      m_cidx  = 0;
    end
    m_page = np;
    drops = 0;
    for (int i = 0; i < NV; i++) begin
      if (note_end_in[i] && m_open[i]) begin
        m_open[i] = 0;
        r = int'(rhythm_in[4*i +: 4]);
        if (r != 0) begin
          if (m_pend[i]) drops++;
          m_pend[i]  = 1;
          m_pcell[i] = (m_spage[i] == np) ? m_scell[i] : 0;
          m_pnote[i] = int'(note_in[8*i +: 8]);
          m_prhy[i]  = r;
        end
      end
      if (note_start_in[i]) begin
        if (m_open[i]) drops++;
        m_open[i]  = 1;
        m_scell[i] = int'(current_cell_in);
        m_spage[i] = np;
      end
    end
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  int         cyc = 0;
  int         n_clr_wr = 0;
  int         n_grant = 0;
  logic [8:0] first_clr_addr;
  logic [8:0] last_clr_addr;
  logic [8:0]  wr_addr [$];
  logic [11:0] wr_data [$];
  int          wr_cyc  [$];

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
    cyc++;
    check_eq("port", 32'({rd_grant_out, mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out}), 32'(e_port));
    check_eq("clearing", 32'(clearing_out), 32'(e_clr));
    check_eq("drop_count", 32'(drop_count_out), 32'(m_drop));
    if (mem_en_out && mem_we_out) begin
      if (clearing_out) begin
        if (n_clr_wr == 0) first_clr_addr = mem_addr_out;
        n_clr_wr++;
        last_clr_addr = mem_addr_out;
      end else begin
        wr_addr.push_back(mem_addr_out);
        wr_data.push_back(mem_wdata_out);
        wr_cyc.push_back(cyc);
      end
    end
    if (rd_grant_out) n_grant++;
    note_start_in = '0;
    note_end_in   = '0;
    cell_tick_in  = 1'b0;
  endtask

  int n0;
  int g0;
  int cur_cell;

  initial begin
    rst_in = 1'b1; cell_tick_in = 1'b0; current_cell_in = '0;
    note_start_in = '0; note_end_in = '0; note_in = '0; rhythm_in = '0;
    rd_req_in = 1'b0; rd_addr_in = '0;
    cur_cell = 0;

    // Reset, then the power-up clear sweep with no other traffic.
    repeat (3) step();
    rst_in = 1'b0;
    repeat (330) step();
    check_eq("clr_count", 32'(n_clr_wr), 32'd320);
    check_eq("clr_first", 32'(first_clr_addr), 32'h000);
    check_eq("clr_last", 32'(last_clr_addr), 32'h1FC);
    check_eq("clr_done", 32'(clearing_out), 32'd0);

    // Voice 2 note at cell 10.
    current_cell_in = 6'd10; cur_cell = 10;
    note_start_in[2] = 1'b1; step();
    repeat (3) step();
    note_end_in[2] = 1'b1; note_in[8*2 +: 8] = 8'h34; rhythm_in[4*2 +: 4] = 4'd4;
    n0 = wr_addr.size();
    repeat (4) step();
    check_eq("v2_count", 32'(wr_addr.size()), 32'(n0 + 1));
    check_eq("v2_addr", 32'(wr_addr[n0]), 32'h052);
    check_eq("v2_data", 32'(wr_data[n0]), 32'h434);

    // Voice 4 brings the pointer back to 0, then voices 0 and 3 end together.
    note_start_in[4] = 1'b1; step();
    note_end_in[4] = 1'b1; rhythm_in[4*4 +: 4] = 4'd1; note_in[8*4 +: 8] = 8'h11;
    repeat (4) step();
    note_start_in = 5'b01001; step();
    note_end_in = 5'b01001;
    rhythm_in[0 +: 4] = 4'd2; note_in[0 +: 8] = 8'h20;
    rhythm_in[12 +: 4] = 4'd3; note_in[24 +: 8] = 8'h73;
    n0 = wr_addr.size();
    repeat (5) step();
    check_eq("pair_count", 32'(wr_addr.size()), 32'(n0 + 2));
    check_eq("pair_first", 32'(wr_addr[n0]), 32'h050);
    check_eq("pair_second", 32'(wr_addr[n0 + 1]), 32'h053);
    check_eq("pair_gap", 32'(wr_cyc[n0 + 1] - wr_cyc[n0]), 32'd1);

    // Display read held for 5 cycles while a write is pending.
    note_start_in[1] = 1'b1; step();
    note_end_in[1] = 1'b1; rhythm_in[4 +: 4] = 4'd5; note_in[8 +: 8] = 8'h56;
    rd_req_in = 1'b1;
    g0 = n_grant;
    n0 = wr_addr.size();
    repeat (5) begin
      rd_addr_in = 9'($urandom);
      step();
    end
    rd_req_in = 1'b0;
    check_eq("stall_grants", 32'(n_grant - g0), 32'd5);
    check_eq("stall_nowrite", 32'(wr_addr.size()), 32'(n0));
    step();
    check_eq("stall_release", 32'(wr_addr.size()), 32'(n0 + 1));
    repeat (2) step();

    // Note spanning the page wrap is clamped to cell 0 and written after the clear.
    current_cell_in = 6'd62; cur_cell = 62;
    note_start_in[1] = 1'b1; step();
    repeat (2) step();
    current_cell_in = 6'd0; cur_cell = 0; cell_tick_in = 1'b1;
    n_clr_wr = 0;
    step();
    note_end_in[1] = 1'b1; rhythm_in[4 +: 4] = 4'd8; note_in[8 +: 8] = 8'h9A;
    n0 = wr_addr.size();
    repeat (340) step();
    check_eq("wrap_clr_count", 32'(n_clr_wr), 32'd320);
    check_eq("wrap_count", 32'(wr_addr.size()), 32'(n0 + 1));
    check_eq("wrap_addr", 32'(wr_addr[n0]), 32'h001);
    check_eq("wrap_data", 32'(wr_data[n0]), 32'h89A);

    // Unquantizable rhythm produces no write.
    note_start_in[0] = 1'b1; step();
    note_end_in[0] = 1'b1; rhythm_in[0 +: 4] = 4'd0;
    n0 = wr_addr.size();
    repeat (4) step();
    check_eq("rhythm0_nowrite", 32'(wr_addr.size()), 32'(n0));

    // Double start drops one note; many more saturate the counter.
    note_start_in[4] = 1'b1; step();
    note_start_in[4] = 1'b1; step();
    check_eq("drop_one", 32'(drop_count_out), 32'd1);
    repeat (300) begin
      note_start_in[4] = 1'b1;
      step();
    end
    check_eq("drop_sat", 32'(drop_count_out), 32'd255);

    // Random traffic with a mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      rd_req_in  = ($urandom_range(3) == 0);
      rd_addr_in = 9'($urandom);
      for (int i = 0; i < NV; i++) begin
        note_start_in[i]    = ($urandom_range(15) == 0);
        note_end_in[i]      = ($urandom_range(11) == 0);
        note_in[8*i +: 8]   = 8'($urandom);
        rhythm_in[4*i +: 4] = 4'($urandom_range(15));
      end
      if ($urandom_range(7) == 0) begin
        cur_cell        = (cur_cell + 1) % 64;
        current_cell_in = 6'(cur_cell);
        cell_tick_in    = 1'b1;
      end
      if (c == 1500) rst_in = 1'b1;
      if (c == 1502) rst_in = 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
